// File: rtl/vga_pattern_controller.sv
// Colour/pattern source between the VGA timing generator and the DAC pins.
// next/prev step a 3-bit colour index with hold-to-repeat; mode_btn cycles four test patterns.
`timescale 1ns/1ps
module vga_pattern_controller #(
   parameter int unsigned COLOR_W       = 4,
   parameter int unsigned X_W           = 11,
   parameter int unsigned Y_W           = 11,
   parameter int unsigned BAR_SHIFT     = 6,
   parameter int unsigned CHECK_SHIFT   = 5,
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic               CLK50MHZ,
   input  logic               RST_N,
   input  logic               next,
   input  logic               prev,
   input  logic               mode_btn,
   input  logic [X_W-1:0]     x,
   input  logic [Y_W-1:0]     y,
   input  logic               displaying,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B,
   output logic [2:0]         color_idx,
   output logic [1:0]         mode
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_next_q, dir_next_d;
   logic               next_q, prev_q, mode_btn_q;
   logic [2:0]         color_idx_q, color_idx_d;
   logic [1:0]         mode_q, mode_d;
   logic [COLOR_W-1:0] vga_r_q, vga_r_d;
   logic [COLOR_W-1:0] vga_g_q, vga_g_d;
   logic [COLOR_W-1:0] vga_b_q, vga_b_d;

   logic       step_c;
   logic       step_up_c;
   logic       held_c;
   logic [2:0] vbar_c, hbar_c, pix_c;
   logic       unused_ok_c;

   // Button FSM: edge-triggered first step, then hold delay, then periodic repeat
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dir_next_d = dir_next_q;
      step_c     = 1'b0;
      step_up_c  = dir_next_q;
      held_c     = dir_next_q ? next : prev;

      if (next && prev) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (next && !next_q) begin
                  step_c     = 1'b1;
                  step_up_c  = 1'b1;
                  dir_next_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = S_HOLD;
               end else if (prev && !prev_q) begin
                  step_c     = 1'b1;
                  step_up_c  = 1'b0;
                  dir_next_d = 1'b0;
                  cnt_d      = '0;
                  state_d    = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!held_c) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else if (cnt_q == HOLD_LAST) begin
                  step_c  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_REPEAT: begin
               if (!held_c) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else if (cnt_q == REPEAT_LAST) begin
                  step_c = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Colour index, mode and pixel colour for the registered output stage
   always_comb begin
      color_idx_d = color_idx_q;
      if (step_c) begin
         color_idx_d = step_up_c ? color_idx_q + 3'd1 : color_idx_q - 3'd1;
      end

      mode_d = (mode_btn && !mode_btn_q) ? mode_q + 2'd1 : mode_q;

      vbar_c = x[BAR_SHIFT+2 -: 3];
      hbar_c = y[BAR_SHIFT+2 -: 3];
      case (mode_q)
         2'd0:    pix_c = color_idx_q;
         2'd1:    pix_c = color_idx_q + vbar_c;
         2'd2:    pix_c = color_idx_q + hbar_c;
         default: pix_c = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? ~color_idx_q : color_idx_q;
      endcase

      vga_r_d = {COLOR_W{displaying & pix_c[0]}};
      vga_g_d = {COLOR_W{displaying & pix_c[1]}};
      vga_b_d = {COLOR_W{displaying & pix_c[2]}};
   end

   always_ff @(posedge CLK50MHZ or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dir_next_q  <= 1'b0;
         next_q      <= 1'b0;
         prev_q      <= 1'b0;
         mode_btn_q  <= 1'b0;
         color_idx_q <= 3'd1;
         mode_q      <= 2'd0;
         vga_r_q     <= '0;
         vga_g_q     <= '0;
         vga_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_next_q  <= dir_next_d;
         next_q      <= next;
         prev_q      <= prev;
         mode_btn_q  <= mode_btn;
         color_idx_q <= color_idx_d;
         mode_q      <= mode_d;
         vga_r_q     <= vga_r_d;
         vga_g_q     <= vga_g_d;
         vga_b_q     <= vga_b_d;
      end
   end

   // Only a few coordinate bits select bars/checkers
   assign unused_ok_c = ^{x, y};

   assign VGA_R     = vga_r_q;
   assign VGA_G     = vga_g_q;
   assign VGA_B     = vga_b_q;
   assign color_idx = color_idx_q;
   assign mode      = mode_q;

endmodule

// File: tb/tb_vga_pattern_controller.sv
// Self-checking bench for vga_pattern_controller with short hold/repeat timing (10/4).
`timescale 1ns/1ps
module tb_vga_pattern_controller;

   localparam int unsigned CW   = 4;
   localparam int unsigned HOLD = 10;
   localparam int unsigned REP  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          next, prev, mode_btn, displaying;
   logic [10:0]   x, y;
   logic [CW-1:0] vga_r, vga_g, vga_b;
   logic [2:0]    color_idx;
   logic [1:0]    mode;

   int errors = 0;
   int checks = 0;
   logic [3*CW-1:0] exp_q[$];
   logic [2:0] m_idx;
   logic [1:0] m_mode;

   vga_pattern_controller #(
      .COLOR_W(CW), .X_W(11), .Y_W(11), .BAR_SHIFT(6), .CHECK_SHIFT(5),
      .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .CLK50MHZ(clk), .RST_N(rst_n), .next(next), .prev(prev), .mode_btn(mode_btn),
      .x(x), .y(y), .displaying(displaying),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .color_idx(color_idx), .mode(mode)
   );

   always #10 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   function automatic logic [2:0] pix(input logic [2:0] idx, input logic [1:0] md,
                                      input logic [10:0] xx, input logic [10:0] yy);
      case (md)
         2'd0:    return idx;
         2'd1:    return idx + xx[8:6];
         2'd2:    return idx + yy[8:6];
         default: return (xx[5] ^ yy[5]) ? ~idx : idx;
      endcase
   endfunction

   function automatic logic [3*CW-1:0] rgb(input logic [2:0] p, input logic dp);
      return {{CW{dp & p[2]}}, {CW{dp & p[1]}}, {CW{dp & p[0]}}};
   endfunction

   // One clock: drive inputs, queue the pixel the output register must show, check it after the edge
   task automatic drive(input logic nx, input logic pv, input logic mb,
                        input logic [10:0] xx, input logic [10:0] yy, input logic dp);
      logic [3*CW-1:0] e, got;
      next = nx; prev = pv; mode_btn = mb; x = xx; y = yy; displaying = dp;
      exp_q.push_back(rgb(pix(m_idx, m_mode, xx, yy), dp));
      @(posedge clk); #1;
      got = {vga_b, vga_g, vga_r};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got=%h", got);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL pixel x=%0d y=%0d mode=%0d got=%h exp=%h", xx, yy, m_mode, got, e);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; next = 0; prev = 0; mode_btn = 0; x = '0; y = '0; displaying = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({vga_b, vga_g, vga_r, color_idx, mode} !== {12'h000, 3'd1, 2'd0}) begin
         errors++;
         $display("FAIL reset_state got rgb=%h idx=%0d mode=%0d", {vga_b, vga_g, vga_r}, color_idx, mode);
      end
      rst_n = 1'b1;
      m_idx = 3'd1; m_mode = 2'd0;
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      checks++;
      if ({vga_b, vga_g, vga_r} !== 12'h00F) begin
         errors++;
         $display("FAIL reset_solid got=%h exp=00F", {vga_b, vga_g, vga_r});
      end
   endtask

   task automatic test_step_wrap();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 11'd0, 11'd0, 1);
         m_idx = m_idx + 3'd1;
         checks++;
         if (color_idx !== m_idx) begin
            errors++;
            $display("FAIL next_step%0d got=%0d exp=%0d", i, color_idx, m_idx);
         end
         drive(0, 0, 0, 11'd0, 11'd0, 1);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 11'd0, 11'd0, 1);
         m_idx = m_idx - 3'd1;
         checks++;
         if (color_idx !== m_idx) begin
            errors++;
            $display("FAIL prev_step%0d got=%0d exp=%0d", i, color_idx, m_idx);
         end
         drive(0, 0, 0, 11'd0, 11'd0, 1);
      end
      checks++;
      if (color_idx !== 3'd7) begin
         errors++;
         $display("FAIL prev_wrap got=%0d exp=7", color_idx);
      end
   endtask

   task automatic test_hold_repeat();
      logic [2:0] start;
      start = m_idx;
      for (int c = 0; c < HOLD + 2 * REP; c++) begin
         drive(1, 0, 0, 11'd0, 11'd0, 1);
         if (c == 0 || c == 10 || c == 14) m_idx = m_idx + 3'd1;
         checks++;
         if (color_idx !== m_idx) begin
            errors++;
            $display("FAIL hold_cycle%0d got=%0d exp=%0d", c, color_idx, m_idx);
         end
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      checks++;
      if (color_idx !== start + 3'd3) begin
         errors++;
         $display("FAIL hold_total got=%0d exp=%0d", color_idx, start + 3'd3);
      end
   endtask

   task automatic test_both_pressed();
      drive(1, 0, 0, 11'd0, 11'd0, 1);
      m_idx = m_idx + 3'd1;
      drive(1, 0, 0, 11'd0, 11'd0, 1);
      drive(1, 0, 0, 11'd0, 11'd0, 1);
      for (int c = 0; c < 3; c++) drive(1, 1, 0, 11'd0, 11'd0, 1);
      checks++;
      if (color_idx !== m_idx) begin
         errors++;
         $display("FAIL both_no_step got=%0d exp=%0d", color_idx, m_idx);
      end
      // still holding next: no new edge, so the FSM must stay idle
      for (int c = 0; c < 12; c++) drive(1, 0, 0, 11'd0, 11'd0, 1);
      checks++;
      if (color_idx !== m_idx) begin
         errors++;
         $display("FAIL both_idle got=%0d exp=%0d", color_idx, m_idx);
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      drive(1, 0, 0, 11'd0, 11'd0, 1);
      m_idx = m_idx + 3'd1;
      checks++;
      if (color_idx !== m_idx) begin
         errors++;
         $display("FAIL both_new_edge got=%0d exp=%0d", color_idx, m_idx);
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
   endtask

   task automatic test_patterns();
      for (int i = 0; i < 8; i++) begin
         if (m_idx == 3'd0) break;
         drive(0, 1, 0, 11'd0, 11'd0, 1);
         m_idx = m_idx - 3'd1;
         drive(0, 0, 0, 11'd0, 11'd0, 1);
      end
      drive(0, 0, 1, 11'd0, 11'd0, 1);
      m_mode = 2'd1;
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      checks++;
      if (mode !== 2'd1 || color_idx !== 3'd0) begin
         errors++;
         $display("FAIL vbars_setup got mode=%0d idx=%0d exp mode=1 idx=0", mode, color_idx);
      end
      drive(0, 0, 0, 11'd0,   11'd0, 1);
      drive(0, 0, 0, 11'd64,  11'd0, 1);
      checks++;
      if ({vga_b, vga_g, vga_r} !== 12'h00F) begin
         errors++;
         $display("FAIL vbar_x64 got=%h exp=00F", {vga_b, vga_g, vga_r});
      end
      drive(0, 0, 0, 11'd448, 11'd0, 1);
      checks++;
      if ({vga_b, vga_g, vga_r} !== 12'hFFF) begin
         errors++;
         $display("FAIL vbar_x448 got=%h exp=FFF", {vga_b, vga_g, vga_r});
      end
      drive(0, 0, 0, 11'd512, 11'd0, 1);
      drive(0, 0, 1, 11'd0, 11'd0, 1);
      m_mode = 2'd2;
      drive(0, 0, 0, 11'd0, 11'd64, 1);
      drive(0, 0, 0, 11'd64, 11'd128, 1);
      drive(0, 0, 1, 11'd0, 11'd0, 1);
      m_mode = 2'd3;
      drive(0, 0, 0, 11'd32, 11'd0, 1);
      checks++;
      if ({vga_b, vga_g, vga_r} !== 12'hFFF) begin
         errors++;
         $display("FAIL checker_x32 got=%h exp=FFF", {vga_b, vga_g, vga_r});
      end
      drive(0, 0, 0, 11'd32, 11'd32, 1);
      drive(0, 0, 0, 11'd0, 11'd32, 1);
      // mode wraps and next steps in the same cycle
      drive(1, 0, 1, 11'd0, 11'd0, 1);
      m_mode = 2'd0;
      m_idx = m_idx + 3'd1;
      checks++;
      if (mode !== m_mode || color_idx !== m_idx) begin
         errors++;
         $display("FAIL mode_wrap_combo got mode=%0d idx=%0d exp mode=%0d idx=%0d", mode, color_idx, m_mode, m_idx);
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
   endtask

   task automatic test_blank_and_async_reset();
      drive(0, 0, 0, 11'd0, 11'd0, 0);
      checks++;
      if ({vga_b, vga_g, vga_r} !== 12'h000) begin
         errors++;
         $display("FAIL blanking got=%h exp=000", {vga_b, vga_g, vga_r});
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      for (int c = 0; c < HOLD + 2; c++) begin
         drive(1, 0, 0, 11'd0, 11'd0, 1);
         if (c == 0 || c == 10) m_idx = m_idx + 3'd1;
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({vga_b, vga_g, vga_r, color_idx, mode} !== {12'h000, 3'd1, 2'd0}) begin
         errors++;
         $display("FAIL async_reset got rgb=%h idx=%0d mode=%0d", {vga_b, vga_g, vga_r}, color_idx, mode);
      end
      next = 1'b0;
      m_idx = 3'd1; m_mode = 2'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(0, 0, 0, 11'd0, 11'd0, 1);
      drive(1, 0, 0, 11'd0, 11'd0, 1);
      m_idx = m_idx + 3'd1;
      checks++;
      if (color_idx !== m_idx) begin
         errors++;
         $display("FAIL post_reset_step got=%0d exp=%0d", color_idx, m_idx);
      end
      drive(0, 0, 0, 11'd0, 11'd0, 1);
   endtask

   initial begin
      test_reset();
      test_step_wrap();
      test_hold_repeat();
      test_both_pressed();
      test_patterns();
      test_blank_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
